// File: rtl/drum_column_engine.sv
// One column of drum nodes: holds u_n and u_n-1 for every row and advances the
// whole column one time step per start, streaming centres to neighbour columns.
module drum_column_engine #(
  parameter int DATA_W    = 18,
  parameter int FRAC_W    = 17,
  parameter int MAX_ROWS  = 32,
  parameter int ROW_W     = 5,
  parameter int BOUNDARY  = 0,
  parameter int ETA_SHIFT = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ROW_W-1:0]         height,
  input  logic signed [DATA_W-1:0] rho,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     out_valid,
  output logic [ROW_W-1:0]         out_row,
  output logic signed [DATA_W-1:0] out_center,
  input  logic signed [DATA_W-1:0] node_left,
  input  logic signed [DATA_W-1:0] node_right,
  input  logic                     ld_en,
  input  logic                     ld_prev,
  input  logic [ROW_W-1:0]         ld_row,
  input  logic signed [DATA_W-1:0] ld_val,
  input  logic [ROW_W-1:0]         tap_row,
  output logic signed [DATA_W-1:0] tap_val
);

  // state  | meaning
  // IDLE   | loads accepted, waiting for start
  // SWEEP  | cycles 0..H: stream row k, write back row k-1
  // DRAIN  | cycle H+1: write back row H
  // DONE   | cycle H+2: done pulse
  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  localparam int CNT_W = ROW_W + 1;
  localparam int VEL_W = DATA_W + 1;
  localparam int LAP_W = DATA_W + 3;
  localparam int ACC_W = 2 * DATA_W + 4;
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(MAX_ROWS - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [ROW_W-1:0]           h_q;
  logic signed [DATA_W-1:0]   rho_q;
  logic signed [DATA_W-1:0]   u_cur_q  [MAX_ROWS];
  logic signed [DATA_W-1:0]   u_prev_q [MAX_ROWS];
  logic signed [DATA_W-1:0]   c_q, up_q, tap_q;

  logic [ROW_W-1:0]           h_clamp, rd_row, wb_row;
  logic                       ld_ok, accept, load, wb_en, edge_up, edge_dn;
  logic signed [DATA_W-1:0]   u_c, u_p, u_u, u_d, u_sat, u_next;
  logic signed [VEL_W-1:0]    vel;
  logic signed [LAP_W-1:0]    lap;
  logic signed [ACC_W-1:0]    prod, acc;

  generate
    if (MAX_ROWS >= (1 << ROW_W)) begin : g_full_range
      assign h_clamp = height;
      assign ld_ok   = 1'b1;
    end else begin : g_clamp
      assign h_clamp = (height > ROW_MAX) ? ROW_MAX : height;
      assign ld_ok   = (ld_row <= ROW_MAX);
    end
  endgenerate

  assign accept = (state_q == S_IDLE) && start;
  assign load   = (state_q == S_IDLE) && ld_en && ld_ok;
  assign rd_row = cnt_q[ROW_W-1:0];
  assign wb_row = ROW_W'(cnt_q - CNT_W'(1));
  assign wb_en  = ((state_q == S_SWEEP) && (cnt_q != '0)) || (state_q == S_DRAIN);

  // c_q/up_q hold the pre-step values of rows k and k-1, since row k-1 is
  // already overwritten when row k is computed.
  assign edge_up = (wb_row == '0);
  assign edge_dn = (wb_row == h_q);
  assign u_c = c_q;
  assign u_p = u_prev_q[wb_row];
  assign u_u = edge_up ? ((BOUNDARY != 0) ? u_c : '0) : up_q;
  assign u_d = edge_dn ? ((BOUNDARY != 0) ? u_c : '0) : u_cur_q[rd_row];

  assign vel  = VEL_W'(u_c) - VEL_W'(u_p);
  assign lap  = LAP_W'(node_left) + LAP_W'(node_right) + LAP_W'(u_u) + LAP_W'(u_d)
              - (LAP_W'(u_c) <<< 2);
  assign prod = ACC_W'(rho_q) * ACC_W'(lap);
  assign acc  = ACC_W'(u_c) + ACC_W'(vel) - ACC_W'(vel >>> ETA_SHIFT) + (prod >>> FRAC_W);

  assign u_sat  = (acc > SAT_HI) ? SAT_HI[DATA_W-1:0] :
                  (acc < SAT_LO) ? SAT_LO[DATA_W-1:0] : acc[DATA_W-1:0];
  assign u_next = ((BOUNDARY == 0) && (edge_up || edge_dn)) ? '0 : u_sat;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SWEEP;
          cnt_d   = '0;
        end
      end
      S_SWEEP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == {1'b0, h_q}) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      h_q     <= '0;
      rho_q   <= '0;
      c_q     <= '0;
      up_q    <= '0;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tap_q   <= u_cur_q[tap_row];
      if (accept) begin
        h_q   <= h_clamp;
        rho_q <= rho;
      end
      if (state_q == S_SWEEP) begin
        up_q <= c_q;
        c_q  <= u_cur_q[rd_row];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_ROWS; i++) begin
        u_cur_q[i]  <= '0;
        u_prev_q[i] <= '0;
      end
    end else begin
      if (load) begin
        if (ld_prev) u_prev_q[ld_row] <= ld_val;
        else         u_cur_q[ld_row]  <= ld_val;
      end
      if (wb_en) begin
        u_cur_q[wb_row]  <= u_next;
        u_prev_q[wb_row] <= c_q;
      end
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign out_valid  = (state_q == S_SWEEP);
  assign out_row    = out_valid ? rd_row : '0;
  assign out_center = out_valid ? u_cur_q[rd_row] : '0;
  assign tap_val    = tap_q;

endmodule

// File: tb/tb_drum_column_engine.sv
// Directed bench for drum_column_engine: a clamped-boundary column with zero
// neighbours plus a free-boundary column fed constant neighbours.
module tb_drum_column_engine;
  localparam int DW = 18;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic reset;
  logic [RW-1:0] height, ld_row, tap_row;
  logic signed [DW-1:0] rho, ld_val, nb_zero, nb_free;
  logic start, ld_en, ld_prev;

  logic busy, done, out_valid;
  logic [RW-1:0] out_row;
  logic signed [DW-1:0] out_center, tap_val;
  logic f_busy, f_done, f_out_valid;
  logic [RW-1:0] f_out_row;
  logic signed [DW-1:0] f_out_center, f_tap_val;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  drum_column_engine #(.BOUNDARY(0)) dut (
    .clk(clk), .reset(reset), .height(height), .rho(rho), .start(start),
    .busy(busy), .done(done), .out_valid(out_valid), .out_row(out_row),
    .out_center(out_center), .node_left(nb_zero), .node_right(nb_zero),
    .ld_en(ld_en), .ld_prev(ld_prev), .ld_row(ld_row), .ld_val(ld_val),
    .tap_row(tap_row), .tap_val(tap_val)
  );

  drum_column_engine #(.BOUNDARY(1)) dut_f (
    .clk(clk), .reset(reset), .height(height), .rho(rho), .start(start),
    .busy(f_busy), .done(f_done), .out_valid(f_out_valid), .out_row(f_out_row),
    .out_center(f_out_center), .node_left(nb_free), .node_right(nb_free),
    .ld_en(ld_en), .ld_prev(ld_prev), .ld_row(ld_row), .ld_val(ld_val),
    .tap_row(tap_row), .tap_val(f_tap_val)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // All tasks are entered and left just after a falling edge.
  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic load(input logic p, input int row, input int val);
    ld_en   = 1'b1;
    ld_prev = p;
    ld_row  = row[RW-1:0];
    ld_val  = val[DW-1:0];
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic read_tap(input int row, output int v, output int vf);
    tap_row = row[RW-1:0];
    @(negedge clk);
    v  = tap_val;
    vf = f_tap_val;
  endtask

  task automatic kick(input int h, input int r);
    height = h[RW-1:0];
    rho    = r[DW-1:0];
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Follows one step from cycle 0; poke drives a load into row 10 in cycle 0.
  task automatic watch(input int h, input bit poke, output int done_cyc,
                       output int nvalid, output int row_err, output int center_nz);
    done_cyc = -1; nvalid = 0; row_err = 0; center_nz = 0;
    for (int c = 0; c < 100; c++) begin
      if (out_valid) begin
        nvalid++;
        if (int'(out_row) != c || c > h) row_err++;
        if (out_center != 0) center_nz++;
      end
      if (busy !== 1'b1) row_err++;
      if (done) begin
        done_cyc = c;
        break;
      end
      ld_en   = poke && (c == 0);
      ld_prev = 1'b0;
      ld_row  = 5'd10;
      ld_val  = 18'sd999;
      @(negedge clk);
    end
    ld_en = 1'b0;
  endtask

  initial begin
    int dc, nv, re, cnz, v, vf, n_done, n_idle;
    int exp_a[5];
    int done_at[3];

    reset = 1'b0; start = 1'b0; ld_en = 1'b0; ld_prev = 1'b0;
    height = '0; rho = '0; ld_row = '0; ld_val = '0; tap_row = '0;
    nb_zero = '0; nb_free = 18'sd65536;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_row", out_row, 0);
    check("rst_center", out_center, 0);
    check("rst_tap", tap_val, 0);
    reset = 1'b1;
    @(negedge clk);

    // Mid-sweep asynchronous reset
    load(1'b0, 2, 65536);
    kick(4, 32768);
    check("midrst_busy_before", busy, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    read_tap(2, v, vf);
    check("midrst_tap2", v, 0);

    // Zero field
    do_reset();
    kick(4, 32768);
    watch(4, 1'b0, dc, nv, re, cnz);
    check("zero_done_cyc", dc, 6);
    check("zero_nvalid", nv, 5);
    check("zero_row_err", re, 0);
    check("zero_center", cnz, 0);
    @(negedge clk);
    check("zero_idle", busy, 0);
    for (int r = 0; r < 5; r++) begin
      read_tap(r, v, vf);
      check($sformatf("zero_row%0d", r), v, 0);
    end

    // Impulse, then a rho=0 step that exposes the written-back u_prev
    do_reset();
    load(1'b0, 2, 65536);
    load(1'b1, 2, 65536);
    kick(4, 32768);
    watch(4, 1'b0, dc, nv, re, cnz);
    check("imp_done_cyc", dc, 6);
    @(negedge clk);
    exp_a = '{0, 16384, 0, 16384, 0};
    for (int r = 0; r < 5; r++) begin
      read_tap(r, v, vf);
      check($sformatf("imp_row%0d", r), v, exp_a[r]);
    end
    kick(4, 0);
    watch(4, 1'b0, dc, nv, re, cnz);
    @(negedge clk);
    exp_a = '{0, 32752, -65472, 32752, 0};
    for (int r = 0; r < 5; r++) begin
      read_tap(r, v, vf);
      check($sformatf("imp2_row%0d", r), v, exp_a[r]);
    end

    // Saturation both ways
    do_reset();
    load(1'b0, 2, 117965);
    load(1'b1, 2, -117965);
    kick(4, 0);
    watch(4, 1'b0, dc, nv, re, cnz);
    @(negedge clk);
    read_tap(2, v, vf);
    check("sat_pos", v, 131071);
    do_reset();
    load(1'b0, 2, -117965);
    load(1'b1, 2, 117965);
    kick(4, 0);
    watch(4, 1'b0, dc, nv, re, cnz);
    @(negedge clk);
    read_tap(2, v, vf);
    check("sat_neg", v, -131072);

    // Load and start on the same edge; a load while busy is dropped
    do_reset();
    height = 5'd4; rho = '0;
    ld_en = 1'b1; ld_prev = 1'b0; ld_row = 5'd2; ld_val = 18'sd65536;
    start = 1'b1;
    @(negedge clk);
    ld_en = 1'b0; start = 1'b0;
    watch(4, 1'b1, dc, nv, re, cnz);
    check("ldst_done_cyc", dc, 6);
    @(negedge clk);
    read_tap(2, v, vf);
    check("ldst_row2", v, 131008);
    read_tap(10, v, vf);
    check("busy_load_row10", v, 0);

    // Free vs clamped boundary
    do_reset();
    for (int r = 0; r < 5; r++) begin
      load(1'b0, r, 65536);
      load(1'b1, r, 65536);
    end
    kick(4, 32768);
    watch(4, 1'b0, dc, nv, re, cnz);
    @(negedge clk);
    for (int r = 0; r < 5; r++) begin
      read_tap(r, v, vf);
      check($sformatf("free_row%0d", r), vf, 65536);
      if (r == 0) check("clamp_row0", v, 0);
      if (r == 1) check("clamp_row1", v, 32768);
    end

    // Back-to-back steps with start held high
    do_reset();
    height = 5'd4; rho = '0; start = 1'b1;
    n_done = 0; n_idle = 0;
    done_at = '{-1, -1, -1};
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (done) begin
        if (n_done < 3) done_at[n_done] = c;
        n_done++;
      end
      if (!busy) n_idle++;
    end
    start = 1'b0;
    check("b2b_ndone", n_done, 3);
    check("b2b_nidle", n_idle, 3);
    check("b2b_done0", done_at[0], 6);
    check("b2b_done1", done_at[1], 14);
    check("b2b_done2", done_at[2], 22);
    @(negedge clk);
    check("b2b_idle_after", busy, 0);

    // Tallest column
    do_reset();
    kick(31, 0);
    watch(31, 1'b0, dc, nv, re, cnz);
    check("h31_done_cyc", dc, 33);
    check("h31_nvalid", nv, 32);
    check("h31_row_err", re, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
